// File: rtl/branch_history_table_ng.sv
// ---------------------------------------------------------------------------
// branch_history_table_ng
//   Local branch history table (one shift register per PC index) with a
//   global history register beside it. After reset or flush a hardware sweep
//   zeroes one entry per cycle; the table reports ready once the sweep ends.
//
// Optional feature macro: BHT_BYPASS_EN
//   When defined, a read of the entry being updated in the same cycle returns
//   the post-update history. When undefined, no forwarding path exists.
//
// Ports
//   clk          system clock (rising edge)
//   rst          asynchronous active-high reset
//   flush        restart the clear sweep, zero the GHR
//   ready        table valid (low while sweeping)
//   rd_index     fetch-side lookup index
//   rd_hist      history of entry rd_index (combinational)
//   upd_valid    resolved branch this cycle
//   upd_index    resolved branch index
//   upd_taken    resolved outcome (1 = taken)
//   upd_hist     pre-update history of entry upd_index (combinational)
//   spec_valid   speculative GHR shift from fetch
//   spec_taken   predicted direction
//   repair       mispredict repair of the GHR
//   repair_ghr   GHR snapshot from fetch of the mispredicted branch
//   repair_taken actual outcome of the mispredicted branch
//   ghr          current global history
// ---------------------------------------------------------------------------
module branch_history_table_ng #(
  parameter  int ENTRIES = 32,
  parameter  int HIST_W  = 5,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              ready,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [HIST_W-1:0] rd_hist,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic              upd_taken,
  output logic [HIST_W-1:0] upd_hist,
  input  logic              spec_valid,
  input  logic              spec_taken,
  input  logic              repair,
  input  logic [HIST_W-1:0] repair_ghr,
  input  logic              repair_taken,
  output logic [HIST_W-1:0] ghr
);

  // state    | meaning
  // ST_CLEAR | sweeping: zero entry clr_ptr each cycle, updates ignored
  // ST_READY | table valid: updates, GHR shifts and repairs accepted
  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam logic [IDX_W:0]   ENTRIES_W = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);

  state_t             state_q;
  logic [IDX_W-1:0]   clr_ptr_q;
  logic               ready_q;
  logic [HIST_W-1:0]  ghr_q, ghr_d;
  logic [HIST_W-1:0]  data_q [ENTRIES];

  logic               rd_in_range, upd_in_range, upd_en;
  logic [HIST_W-1:0]  rd_old, upd_old, upd_next;

  // Widened compare so non-power-of-two tables reject indices >= ENTRIES.
  assign rd_in_range  = ({1'b0, rd_index}  < ENTRIES_W);
  assign upd_in_range = ({1'b0, upd_index} < ENTRIES_W);
  assign upd_en       = upd_valid && ready_q && upd_in_range;

  assign rd_old   = (ready_q && rd_in_range)  ? data_q[rd_index]  : '0;
  assign upd_old  = (ready_q && upd_in_range) ? data_q[upd_index] : '0;
  assign upd_next = {upd_old[HIST_W-2:0], upd_taken};

  assign upd_hist = upd_old;

`ifdef BHT_BYPASS_EN
  assign rd_hist = (upd_en && (rd_index == upd_index)) ? upd_next : rd_old;
`else
  assign rd_hist = rd_old;
`endif

  always_comb begin
    ghr_d = ghr_q;
    if (state_q == ST_READY) begin
      if (flush)
        ghr_d = '0;
      else if (repair)
        ghr_d = {repair_ghr[HIST_W-2:0], repair_taken};
      else if (spec_valid)
        ghr_d = {ghr_q[HIST_W-2:0], spec_taken};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      ghr_q     <= '0;
    end else begin
      ghr_q <= ghr_d;
      case (state_q)
        ST_CLEAR: begin
          if (flush) begin
            clr_ptr_q <= '0;
          end else if (clr_ptr_q == LAST_IDX) begin
            clr_ptr_q <= '0;
            state_q   <= ST_READY;
            ready_q   <= 1'b1;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        ST_READY: begin
          if (flush) begin
            clr_ptr_q <= '0;
            state_q   <= ST_CLEAR;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_ptr_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep is what zeroes it. clr_ptr_q never
  // exceeds ENTRIES-1, so the clear write is always in range.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR)
      data_q[clr_ptr_q] <= '0;
    else if (upd_en)
      data_q[upd_index] <= upd_next;
  end

  assign ready = ready_q;
  assign ghr   = ghr_q;

endmodule

// File: tb/tb_branch_history_table_ng.sv
module tb_branch_history_table_ng;

  localparam int HW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: ENTRIES=32
  logic          a_rst, a_flush, a_ready, a_upd_valid, a_upd_taken;
  logic          a_spec_valid, a_spec_taken, a_repair, a_repair_taken;
  logic [4:0]    a_rd_index, a_upd_index;
  logic [HW-1:0] a_rd_hist, a_upd_hist, a_repair_ghr, a_ghr;

  // DUT B: ENTRIES=20 (non-power-of-two)
  logic          b_rst, b_flush, b_ready, b_upd_valid, b_upd_taken;
  logic          b_spec_valid, b_spec_taken, b_repair, b_repair_taken;
  logic [4:0]    b_rd_index, b_upd_index;
  logic [HW-1:0] b_rd_hist, b_upd_hist, b_repair_ghr, b_ghr;

  branch_history_table_ng #(.ENTRIES(32), .HIST_W(HW)) u_dut (
    .clk(clk), .rst(a_rst), .flush(a_flush), .ready(a_ready),
    .rd_index(a_rd_index), .rd_hist(a_rd_hist),
    .upd_valid(a_upd_valid), .upd_index(a_upd_index), .upd_taken(a_upd_taken),
    .upd_hist(a_upd_hist),
    .spec_valid(a_spec_valid), .spec_taken(a_spec_taken),
    .repair(a_repair), .repair_ghr(a_repair_ghr), .repair_taken(a_repair_taken),
    .ghr(a_ghr)
  );

  branch_history_table_ng #(.ENTRIES(20), .HIST_W(HW)) u_dut20 (
    .clk(clk), .rst(b_rst), .flush(b_flush), .ready(b_ready),
    .rd_index(b_rd_index), .rd_hist(b_rd_hist),
    .upd_valid(b_upd_valid), .upd_index(b_upd_index), .upd_taken(b_upd_taken),
    .upd_hist(b_upd_hist),
    .spec_valid(b_spec_valid), .spec_taken(b_spec_taken),
    .repair(b_repair), .repair_ghr(b_repair_ghr), .repair_taken(b_repair_taken),
    .ghr(b_ghr)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic push(input string tag, input logic [7:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    sb_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty obs=%0h exp=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_upd(input logic [4:0] idx, input logic tk);
    a_upd_valid = 1'b1;
    a_upd_index = idx;
    a_upd_taken = tk;
    step();
    a_upd_valid = 1'b0;
  endtask

  task automatic a_spec(input logic tk);
    a_spec_valid = 1'b1;
    a_spec_taken = tk;
    step();
    a_spec_valid = 1'b0;
  endtask

  logic [4:0] t5;

  initial begin
    a_rst = 1'b1; a_flush = 0; a_upd_valid = 0; a_upd_taken = 0; a_upd_index = 0;
    a_rd_index = 0; a_spec_valid = 0; a_spec_taken = 0; a_repair = 0;
    a_repair_ghr = '0; a_repair_taken = 0;
    b_rst = 1'b1; b_flush = 0; b_upd_valid = 0; b_upd_taken = 0; b_upd_index = 0;
    b_rd_index = 0; b_spec_valid = 0; b_spec_taken = 0; b_repair = 0;
    b_repair_ghr = '0; b_repair_taken = 0;

    // ---------------- reset sweep, updates blocked while clearing
    repeat (3) step();
    push("rst_ready", 8'd0); chk({7'd0, a_ready});
    push("rst_ghr", 8'd0);   chk({3'd0, a_ghr});
    a_rst = 1'b0;
    a_upd_valid = 1'b1; a_upd_index = 5'd7; a_upd_taken = 1'b1;
    a_spec_valid = 1'b1; a_spec_taken = 1'b1;
    a_repair = 1'b1; a_repair_ghr = 5'b11111; a_repair_taken = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      push($sformatf("sweep_ready_c%0d", i), {7'd0, (i == 32)});
      chk({7'd0, a_ready});
      push($sformatf("sweep_ghr_c%0d", i), 8'd0);
      chk({3'd0, a_ghr});
    end
    a_upd_valid = 0; a_spec_valid = 0; a_repair = 0;
    for (int i = 0; i < 32; i++) begin
      a_rd_index = 5'(i);
      #1;
      push($sformatf("clear_rd_%0d", i), 8'd0);
      chk({3'd0, a_rd_hist});
    end

    // ---------------- shift pattern on index 3
    a_upd(5'd3, 1); a_upd(5'd3, 0); a_upd(5'd3, 1); a_upd(5'd3, 1); a_upd(5'd3, 0);
    a_rd_index = 5'd3; #1;
    push("shift_5", 8'b10110); chk({3'd0, a_rd_hist});
    a_upd(5'd3, 1);
    #1;
    push("shift_6", 8'b01101); chk({3'd0, a_rd_hist});
    a_rd_index = 5'd4; #1;
    push("neighbour_4", 8'd0); chk({3'd0, a_rd_hist});

    // ---------------- same-cycle read/update of index 7
    a_upd(5'd7, 1);
    a_rd_index = 5'd7;
    a_upd_valid = 1'b1; a_upd_index = 5'd7; a_upd_taken = 1'b1;
    #1;
`ifdef BHT_BYPASS_EN
    push("same_cycle_rd", 8'b00011);
`else
    push("same_cycle_rd", 8'b00001);
`endif
    chk({3'd0, a_rd_hist});
    push("same_cycle_upd_hist", 8'b00001); chk({3'd0, a_upd_hist});
    step();
    a_upd_valid = 1'b0;
    #1;
    push("after_update_rd", 8'b00011); chk({3'd0, a_rd_hist});

    // ---------------- GHR speculative shift and repair priority
    a_spec(0); a_spec(1); a_spec(0); a_spec(1); a_spec(0);
    push("ghr_spec", 8'b01010); chk({3'd0, a_ghr});
    a_spec_valid = 1'b1; a_spec_taken = 1'b1;
    a_repair = 1'b1; a_repair_ghr = 5'b00111; a_repair_taken = 1'b0;
    step();
    a_spec_valid = 0; a_repair = 0;
    push("ghr_repair_wins", 8'b01110); chk({3'd0, a_ghr});
    a_spec(1);
    push("ghr_after_repair", 8'b11101); chk({3'd0, a_ghr});
    a_spec(1); a_spec(0); a_spec(1); a_spec(0); a_spec(1);
    push("ghr_pre_flush", 8'b10101); chk({3'd0, a_ghr});

    // ---------------- flush from READY (flush beats spec_valid)
    a_flush = 1'b1; a_spec_valid = 1'b1; a_spec_taken = 1'b1;
    step();
    a_flush = 0; a_spec_valid = 0;
    push("flush_ready", 8'd0); chk({7'd0, a_ready});
    push("flush_ghr", 8'd0);   chk({3'd0, a_ghr});
    for (int i = 1; i <= 32; i++) begin
      step();
      push($sformatf("flush_sweep_c%0d", i), {7'd0, (i == 32)});
      chk({7'd0, a_ready});
    end
    for (int i = 0; i < 32; i++) begin
      a_rd_index = 5'(i);
      #1;
      push($sformatf("flush_rd_%0d", i), 8'd0);
      chk({3'd0, a_rd_hist});
    end

    // ---------------- flush again, then a re-flush at sweep cycle 10
    a_flush = 1'b1; step(); a_flush = 0;
    for (int i = 1; i <= 9; i++) step();
    push("reflush_mid_ready", 8'd0); chk({7'd0, a_ready});
    a_flush = 1'b1; step(); a_flush = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      push($sformatf("reflush_c%0d", i), {7'd0, (i == 32)});
      chk({7'd0, a_ready});
    end

    // ---------------- ENTRIES=20: async reset mid-sweep
    b_rst = 1'b0;
    repeat (5) step();
    #2;
    b_rst = 1'b1;
    #1;
    push("b_async_rst_ready", 8'd0); chk({7'd0, b_ready});
    step();
    b_rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      push($sformatf("b_sweep_c%0d", i), {7'd0, (i == 20)});
      chk({7'd0, b_ready});
    end

    // out-of-range update/read dropped
    b_upd_valid = 1'b1; b_upd_index = 5'd25; b_upd_taken = 1'b1;
    b_rd_index = 5'd25;
    #1;
    push("b_oor_rd", 8'd0);       chk({3'd0, b_rd_hist});
    push("b_oor_upd_hist", 8'd0); chk({3'd0, b_upd_hist});
    step();
    b_upd_index = 5'd19;
    step();
    b_upd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b_rd_index = 5'(i);
      #1;
      push($sformatf("b_rd_%0d", i), (i == 19) ? 8'd1 : 8'd0);
      chk({3'd0, b_rd_hist});
    end
    t5 = 5'd25;
    b_rd_index = t5;
    #1;
    push("b_oor_rd_after", 8'd0); chk({3'd0, b_rd_hist});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
